xrv1_rf_wb_sched: RTL and testbench
===================================

// Module: xrv1_rf_wb_sched
// PURPOSE
//  Write-back scheduler and scoreboard for the xrv1 integer register file.
//  Shares the single RF write port among NUM_WB_P write-back sources (ALU, LSU, MUL/DIV) with round-robin arbitration.
//  Tracks in-flight destination registers and stalls issue on RAW/WAW hazards.
//  Sits between the issue stage, the functional-unit write-back buses and the RF write port.
// PARAMETERS
//  DATA_WIDTH_P     32  RF data width
//  rf_addr_width_p  5   RF address width; scoreboard depth = 1<<rf_addr_width_p
//  NUM_WB_P         3   number of write-back requesters (>=2)
// PORTS
//  clk_i           in   1                      clock; all state on posedge
//  rst_ni          in   1                      asynchronous reset, active-low
//  iss_valid_i     in   1                      issue stage presents an instruction
//  iss_ready_o     out  1                      no hazard; instruction accepted when valid&ready
//  iss_rd_we_i     in   1                      instruction writes rd
//  iss_rd_addr_i   in   rf_addr_width_p        destination register
//  iss_rs0_addr_i  in   rf_addr_width_p        source 0
//  iss_rs1_addr_i  in   rf_addr_width_p        source 1
//  wb_valid_i      in   NUM_WB_P               per-source write-back request
//  wb_ready_o      out  NUM_WB_P               one-hot grant; transfer when valid&ready
//  wb_addr_i       in   NUM_WB_P x rf_addr_width_p  per-source destination
//  wb_data_i       in   NUM_WB_P x DATA_WIDTH_P     per-source result
//  rd_w_en_o       out  1                      RF write enable (registered)
//  rd_addr_o       out  rf_addr_width_p        RF write address (registered)
//  rd_data_o       out  DATA_WIDTH_P           RF write data (registered)
//  sb_err_o        out  1                      sticky: write-back to a register not marked busy
// BEHAVIOUR
//  Reset (async, rst_ni=0): busy[]=0, rr_ptr=0, rd_w_en_o=0, rd_addr_o=0, rd_data_o=0, sb_err_o=0.
//   Reset takes effect immediately; an in-flight write-back is dropped.
//  Scoreboard: one busy bit per register; busy[0] is hardwired to 0.
//  iss_ready_o is combinational from the registered busy[]:
//   ~(busy[rs0] | busy[rs1] | (iss_rd_we_i & busy[rd])).
//  Issue accept (valid & ready & rd_we & rd!=0): busy[rd] is set next cycle.
//  Arbitration:
//   - Round-robin over wb_valid_i, starting search at rr_ptr.
//   - At most one grant per cycle; wb_ready_o depends only on wb_valid_i and rr_ptr.
//   - On grant of index k: rr_ptr <= (k+1) mod NUM_WB_P. No grant: rr_ptr holds.
//  Output stage, one cycle after a grant:
//   - rd_w_en_o = 1 iff the granted addr != 0; rd_addr_o/rd_data_o = granted addr/data.
//   - No grant: rd_w_en_o=0; addr/data hold their previous values.
//  Busy clear: busy[rd_addr_o] is cleared in the cycle rd_w_en_o=1, i.e. when the RF captures the data.
//   Sources read the new value from the following cycle.
//  Same-cycle set and clear of one register: set wins.
//   Cannot arise through issue, since WAW stalls on the registered busy bit; the rule is defined for safety.
//  A grant with addr!=0 and busy[addr]==0 sets sb_err_o, which holds until reset. The write is still performed.
//  Write-back latency: grant cycle N -> RF write at end of N+1 -> dependent issue possible in N+2.
// CONFIGURATION
//  XRV1_RF_WB_BYPASS_EN defined:
//   - busy[addr] is cleared in the grant cycle instead of the write cycle.
//   - Adds outputs fwd_valid_o = rd_w_en_o, fwd_addr_o = rd_addr_o, fwd_data_o = rd_data_o.
//   - The operand mux uses these while the RF write is pending; a dependent issue is possible in N+1.
//  Undefined: fwd_* ports are absent; busy clears at the write as described above.
// STRUCTURE
//  Package xrv1_rf_pkg:
//   - rf_addr_t, rf_data_t typedefs
//   - wb_req_t struct {valid, addr, data}
//   - localparam RF_SIZE = 1<<rf_addr_width_p
//  Sub-module xrv1_rr_arb #(N): request vector in, one-hot grant and next-pointer out, pointer register inside.
//  Top level holds the scoreboard flops, the hazard logic and the output stage.
// TESTING
//  1. Reset, issue rd=x5 -> busy[5]=1; issue rs0=x5 stalls (ready=0);
//     ALU wb x5=0xDEAD_BEEF -> RF write next cycle; ready=1 one cycle later.
//  2. All three sources valid for 6 cycles -> grants 0,1,2,0,1,2; rr_ptr wraps; each wb_ready_o one-hot.
//  3. Issue rd=x0 -> busy unchanged, no stall; wb to x0 -> granted, rd_w_en_o=0, sb_err_o stays 0.
//  4. wb to x7 with busy[7]=0 -> write performed; sb_err_o=1 and stays 1 until rst_ni low.
//  5. rst_ni low while busy[3]=1 and a grant is pending -> all outputs 0 immediately, busy cleared, iss_ready_o=1.
//  6. XRV1_RF_WB_BYPASS_EN: wb x9 in cycle N -> dependent issue accepted in N+1 with fwd_data_o matching.
//     Without the macro the same issue is accepted in N+2.

Source files
------------

// File: rtl/xrv1_rf_pkg.sv
// Shared types and sizes for the xrv1 register-file write-back path.
// Optional feature macro used by this slice: XRV1_RF_WB_BYPASS_EN.
// The typedefs carry the default widths; top-level parameters default to them.
package xrv1_rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_SIZE   = 1 << RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // One write-back request as seen after arbitration.
  typedef struct packed {
    logic     valid;
    rf_addr_t addr;
    rf_data_t data;
  } wb_req_t;

endpackage

// File: rtl/xrv1_rr_arb.sv
// Round-robin arbiter: one-hot grant over N requesters, search starts at the pointer.
// Latency: grant is combinational from req_i and the registered pointer.
// Backpressure: ungranted requesters simply see no grant; pointer holds when idle.
module xrv1_rr_arb #(
  parameter int N = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N-1:0]                         req_i,
  output logic [N-1:0]                         gnt_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_nxt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Modular add that stays inside 0..N-1 for non-power-of-two N.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= unsigned'(N)) sum = sum - unsigned'(N);
    return sum[PW-1:0];
  endfunction

  // Walk offsets farthest-first so the requester nearest the pointer overwrites the others.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[wrap_add(ptr_q, unsigned'(i))]) begin
        gnt_o = '0;
        gnt_o[wrap_add(ptr_q, unsigned'(i))] = 1'b1;
        ptr_d = wrap_add(ptr_q, unsigned'(i) + 1);
      end
    end
  end

  assign ptr_nxt_o = ptr_d;

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xrv1_rf_wb_sched.sv
// Write-back scheduler + scoreboard: arbitrates FU results onto the single RF write port, stalls issue on RAW/WAW.
// Latency: grant in cycle N, registered RF write at end of N+1; dependent issue in N+2 (N+1 with XRV1_RF_WB_BYPASS_EN).
// Backpressure: iss_ready_o drops while any referenced register is busy; wb_ready_o grants one source per cycle.
module xrv1_rf_wb_sched
  import xrv1_rf_pkg::*;
#(
  parameter int DATA_WIDTH_P    = RF_DATA_W,
  parameter int rf_addr_width_p = RF_ADDR_W,
  parameter int NUM_WB_P        = 3
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     iss_valid_i,
  output logic                                     iss_ready_o,
  input  logic                                     iss_rd_we_i,
  input  logic [rf_addr_width_p-1:0]               iss_rd_addr_i,
  input  logic [rf_addr_width_p-1:0]               iss_rs0_addr_i,
  input  logic [rf_addr_width_p-1:0]               iss_rs1_addr_i,
  input  logic [NUM_WB_P-1:0]                      wb_valid_i,
  output logic [NUM_WB_P-1:0]                      wb_ready_o,
  input  logic [NUM_WB_P-1:0][rf_addr_width_p-1:0] wb_addr_i,
  input  logic [NUM_WB_P-1:0][DATA_WIDTH_P-1:0]    wb_data_i,
  output logic                                     rd_w_en_o,
  output logic [rf_addr_width_p-1:0]               rd_addr_o,
  output logic [DATA_WIDTH_P-1:0]                  rd_data_o,
`ifdef XRV1_RF_WB_BYPASS_EN
  output logic                                     fwd_valid_o,
  output logic [rf_addr_width_p-1:0]               fwd_addr_o,
  output logic [DATA_WIDTH_P-1:0]                  fwd_data_o,
`endif
  output logic                                     sb_err_o
);

  localparam int SB_DEPTH = 1 << rf_addr_width_p;
  localparam int PW       = $clog2(NUM_WB_P);

  logic [SB_DEPTH-1:0]        busy_q, busy_d;
  logic [NUM_WB_P-1:0]        gnt;
  logic [PW-1:0]              ptr_nxt;
  logic [PW-1:0]              win_idx;
  wb_req_t                    win;
  logic                       iss_fire;
  logic                       rd_w_en_q, rd_w_en_d;
  logic [rf_addr_width_p-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH_P-1:0]    rd_data_q, rd_data_d;
  logic                       sb_err_q, sb_err_d;

  xrv1_rr_arb #(
    .N (NUM_WB_P)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (wb_valid_i),
    .gnt_o     (gnt),
    .ptr_nxt_o (ptr_nxt)
  );

  assign wb_ready_o = gnt;

  // Hazard check uses only the registered scoreboard, never same-cycle updates.
  assign iss_ready_o = ~(busy_q[iss_rs0_addr_i] | busy_q[iss_rs1_addr_i] |
                         (iss_rd_we_i & busy_q[iss_rd_addr_i]));
  assign iss_fire    = iss_valid_i & iss_ready_o & iss_rd_we_i & (iss_rd_addr_i != '0);

  // Winner selection: the arbiter's next pointer sits one past the granted index.
  always_comb begin
    win_idx   = (ptr_nxt == '0) ? PW'(NUM_WB_P - 1) : ptr_nxt - 1'b1;
    win.valid = |gnt;
    win.addr  = wb_addr_i[win_idx];
    win.data  = wb_data_i[win_idx];
  end

  // Scoreboard next state: clear first, then set so a same-cycle set wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
`ifdef XRV1_RF_WB_BYPASS_EN
    if (win.valid) busy_d[win.addr] = 1'b0;
`else
    if (rd_w_en_q) busy_d[rd_addr_q] = 1'b0;
`endif
    if (iss_fire) busy_d[iss_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output stage and sticky error: capture the winner, write enable only for non-x0 targets.
  always_comb begin
    rd_w_en_d = win.valid & (win.addr != '0);
    rd_addr_d = win.valid ? win.addr : rd_addr_q;
    rd_data_d = win.valid ? win.data : rd_data_q;
    sb_err_d  = sb_err_q | (win.valid & (win.addr != '0) & ~busy_q[win.addr]);
  end

  // State registers; reset drops any in-flight write-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      rd_w_en_q <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rd_w_en_q <= rd_w_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      sb_err_q  <= sb_err_d;
    end
  end

  assign rd_w_en_o = rd_w_en_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign sb_err_o  = sb_err_q;

`ifdef XRV1_RF_WB_BYPASS_EN
  // The operand mux forwards from the pending RF write.
  assign fwd_valid_o = rd_w_en_q;
  assign fwd_addr_o  = rd_addr_q;
  assign fwd_data_o  = rd_data_q;
`endif

endmodule

// File: tb/tb_xrv1_rf_wb_sched.sv
// Self-checking bench for xrv1_rf_wb_sched: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the scoreboard and arbiter.
// Works with or without XRV1_RF_WB_BYPASS_EN defined.
module tb_xrv1_rf_wb_sched;
  import xrv1_rf_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               iss_valid, iss_we, iss_ready;
  logic [AW-1:0]      iss_rd, iss_rs0, iss_rs1;
  logic [N-1:0]       wb_valid, wb_ready;
  logic [N-1:0][AW-1:0] wb_addr;
  logic [N-1:0][DW-1:0] wb_data;
  logic               rd_w_en, sb_err;
  logic [AW-1:0]      rd_addr;
  logic [DW-1:0]      rd_data;
`ifdef XRV1_RF_WB_BYPASS_EN
  logic               fwd_valid;
  logic [AW-1:0]      fwd_addr;
  logic [DW-1:0]      fwd_data;
`endif

  xrv1_rf_wb_sched #(
    .DATA_WIDTH_P    (DW),
    .rf_addr_width_p (AW),
    .NUM_WB_P        (N)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .iss_valid_i    (iss_valid),
    .iss_ready_o    (iss_ready),
    .iss_rd_we_i    (iss_we),
    .iss_rd_addr_i  (iss_rd),
    .iss_rs0_addr_i (iss_rs0),
    .iss_rs1_addr_i (iss_rs1),
    .wb_valid_i     (wb_valid),
    .wb_ready_o     (wb_ready),
    .wb_addr_i      (wb_addr),
    .wb_data_i      (wb_data),
    .rd_w_en_o      (rd_w_en),
    .rd_addr_o      (rd_addr),
    .rd_data_o      (rd_data),
`ifdef XRV1_RF_WB_BYPASS_EN
    .fwd_valid_o    (fwd_valid),
    .fwd_addr_o     (fwd_addr),
    .fwd_data_o     (fwd_data),
`endif
    .sb_err_o       (sb_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  bit            m_busy [32];
  int            m_ptr;
  bit            m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_err;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_ptr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
  endtask

  // First valid source searching upward from the pointer, or -1.
  function automatic int m_grant();
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (wb_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit m_ready();
    return !(m_busy[iss_rs0] || m_busy[iss_rs1] || (iss_we && m_busy[iss_rd]));
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    int            g;
    bit            r;
    logic [AW-1:0] a;
    g = m_grant();
    r = m_ready();
    a = (g >= 0) ? wb_addr[g] : '0;
    if (g >= 0 && a != 0 && !m_busy[a]) m_err = 1'b1;
`ifdef XRV1_RF_WB_BYPASS_EN
    if (g >= 0) m_busy[a] = 1'b0;
`else
    if (m_wen) m_busy[m_addr] = 1'b0;
`endif
    if (iss_valid && r && iss_we && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_wen  = (a != 0);
      m_addr = a;
      m_data = wb_data[g];
      m_ptr  = (g + 1) % N;
    end else begin
      m_wen = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_rs0 = '0; iss_rs1 = '0;
    wb_valid = '0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if (rd_w_en !== 1'b0) $display("FAIL reset_rd_w_en got=%b want=0", rd_w_en); else n_pass++;
    n_checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got=%0h want=0", rd_addr); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data got=%0h want=0", rd_data); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL reset_sb_err got=%b want=0", sb_err); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got=%b want=1", iss_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_raw_stall();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd5; iss_rs0 = 5'd1; iss_rs1 = 5'd2;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL raw_issue_ready got=%b want=1", iss_ready); else n_pass++;
    cycle();
    iss_we = 1'b0; iss_rd = '0; iss_rs0 = 5'd5; iss_rs1 = '0;
    wb_valid = 3'b001; wb_addr[0] = 5'd5; wb_data[0] = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL raw_stall got=%b want=0", iss_ready); else n_pass++;
    n_checks++; if (wb_ready !== 3'b001) $display("FAIL raw_wb_grant got=%b want=001", wb_ready); else n_pass++;
    cycle();
    wb_valid = '0;
    #1;
    n_checks++; if (rd_w_en !== 1'b1) $display("FAIL raw_rf_we got=%b want=1", rd_w_en); else n_pass++;
    n_checks++; if (rd_addr !== 5'd5) $display("FAIL raw_rf_addr got=%0d want=5", rd_addr); else n_pass++;
    n_checks++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL raw_rf_data got=%h want=deadbeef", rd_data); else n_pass++;
`ifdef XRV1_RF_WB_BYPASS_EN
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL raw_ready_n1 got=%b want=1", iss_ready); else n_pass++;
`else
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL raw_ready_n1 got=%b want=0", iss_ready); else n_pass++;
`endif
    cycle();
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL raw_ready_n2 got=%b want=1", iss_ready); else n_pass++;
    n_checks++; if (rd_w_en !== 1'b0) $display("FAIL raw_we_drop got=%b want=0", rd_w_en); else n_pass++;
    n_checks++; if (rd_data !== 32'hDEAD_BEEF) $display("FAIL raw_data_hold got=%h want=deadbeef", rd_data); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL raw_sb_err got=%b want=0", sb_err); else n_pass++;
    idle();
    cycle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [DW-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wb_valid = 3'b111;
      for (int s = 0; s < N; s++) begin
        wb_addr[s] = '0;
        wb_data[s] = 32'hA000_0000 + 32'(s);
      end
      #1;
      exp_g = 3'b001 << (i % 3);
      n_checks++; if (wb_ready !== exp_g) $display("FAIL rr_grant_%0d got=%b want=%b", i, wb_ready, exp_g); else n_pass++;
      if (i > 0) begin
        exp_d = 32'hA000_0000 + 32'((i - 1) % 3);
        n_checks++; if (rd_data !== exp_d) $display("FAIL rr_data_%0d got=%h want=%h", i, rd_data, exp_d); else n_pass++;
      end
      cycle();
    end
    idle();
    #1;
    n_checks++; if (rd_data !== 32'hA000_0002) $display("FAIL rr_data_last got=%h want=a0000002", rd_data); else n_pass++;
    n_checks++; if (rd_w_en !== 1'b0) $display("FAIL rr_x0_we got=%b want=0", rd_w_en); else n_pass++;
    cycle();
  endtask

  task automatic test_x0();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = '0; iss_rs0 = '0; iss_rs1 = '0;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL x0_issue_ready got=%b want=1", iss_ready); else n_pass++;
    cycle();
    wb_valid = 3'b010; wb_addr[1] = '0; wb_data[1] = 32'h0000_1234;
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL x0_no_stall got=%b want=1", iss_ready); else n_pass++;
    n_checks++; if (wb_ready !== 3'b010) $display("FAIL x0_grant got=%b want=010", wb_ready); else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++; if (rd_w_en !== 1'b0) $display("FAIL x0_we got=%b want=0", rd_w_en); else n_pass++;
    n_checks++; if (rd_data !== 32'h0000_1234) $display("FAIL x0_data got=%h want=00001234", rd_data); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL x0_sb_err got=%b want=0", sb_err); else n_pass++;
    cycle();
  endtask

  task automatic test_sb_err();
    wb_valid = 3'b100; wb_addr[2] = 5'd7; wb_data[2] = 32'h0000_0077;
    #1;
    n_checks++; if (wb_ready !== 3'b100) $display("FAIL err_grant got=%b want=100", wb_ready); else n_pass++;
    cycle();
    idle();
    #1;
    n_checks++; if (rd_w_en !== 1'b1) $display("FAIL err_write_done got=%b want=1", rd_w_en); else n_pass++;
    n_checks++; if (rd_addr !== 5'd7) $display("FAIL err_addr got=%0d want=7", rd_addr); else n_pass++;
    n_checks++; if (sb_err !== 1'b1) $display("FAIL err_set got=%b want=1", sb_err); else n_pass++;
    repeat (3) cycle();
    #1;
    n_checks++; if (sb_err !== 1'b1) $display("FAIL err_sticky got=%b want=1", sb_err); else n_pass++;
    do_reset();
    #1;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL err_cleared got=%b want=0", sb_err); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd3; iss_rs0 = '0; iss_rs1 = '0;
    wb_valid = 3'b010; wb_addr[1] = 5'd7; wb_data[1] = 32'h5555_5555;
    cycle();
    iss_we = 1'b0; iss_rd = '0; iss_rs0 = 5'd3;
    wb_valid = 3'b001; wb_addr[0] = 5'd3; wb_data[0] = 32'h3333_3333;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL ar_busy3 got=%b want=0", iss_ready); else n_pass++;
    n_checks++; if (rd_w_en !== 1'b1) $display("FAIL ar_pre_we got=%b want=1", rd_w_en); else n_pass++;
    n_checks++; if (sb_err !== 1'b1) $display("FAIL ar_pre_err got=%b want=1", sb_err); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if (rd_w_en !== 1'b0) $display("FAIL ar_we got=%b want=0", rd_w_en); else n_pass++;
    n_checks++; if (rd_addr !== '0) $display("FAIL ar_addr got=%0d want=0", rd_addr); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL ar_data got=%h want=0", rd_data); else n_pass++;
    n_checks++; if (sb_err !== 1'b0) $display("FAIL ar_err got=%b want=0", sb_err); else n_pass++;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL ar_ready got=%b want=1", iss_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_checks++; if (rd_data !== '0) $display("FAIL ar_grant_dropped got=%h want=0", rd_data); else n_pass++;
    idle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_fwd_latency();
    logic [DW-1:0] d;
    do_reset();
    d = $urandom;
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd9;
    cycle();
    iss_we = 1'b0; iss_rd = '0; iss_rs0 = 5'd9; iss_rs1 = '0;
    wb_valid = 3'b001; wb_addr[0] = 5'd9; wb_data[0] = d;
    #1;
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL fwd_ready_n got=%b want=0", iss_ready); else n_pass++;
    cycle();
    wb_valid = '0;
    #1;
`ifdef XRV1_RF_WB_BYPASS_EN
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL fwd_ready_n1 got=%b want=1", iss_ready); else n_pass++;
    n_checks++; if (fwd_valid !== 1'b1) $display("FAIL fwd_valid got=%b want=1", fwd_valid); else n_pass++;
    n_checks++; if (fwd_addr !== 5'd9) $display("FAIL fwd_addr got=%0d want=9", fwd_addr); else n_pass++;
    n_checks++; if (fwd_data !== d) $display("FAIL fwd_data got=%h want=%h", fwd_data, d); else n_pass++;
`else
    n_checks++; if (iss_ready !== 1'b0) $display("FAIL fwd_ready_n1 got=%b want=0", iss_ready); else n_pass++;
`endif
    cycle();
    #1;
    n_checks++; if (iss_ready !== 1'b1) $display("FAIL fwd_ready_n2 got=%b want=1", iss_ready); else n_pass++;
    idle();
    cycle();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [N-1:0]  exp_g;
    int            g;
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        iss_valid = 1'($urandom_range(0, 1));
        iss_we    = 1'($urandom_range(0, 3) != 0);
        iss_rd    = 5'($urandom_range(0, 31));
        iss_rs0   = 5'($urandom_range(0, 31));
        iss_rs1   = 5'($urandom_range(0, 31));
        wb_valid  = 3'($urandom_range(0, 7));
        for (int s = 0; s < N; s++) begin
          a = 5'($urandom_range(0, 31));
          for (int t = 0; t < 8 && !m_busy[a]; t++) a = 5'($urandom_range(0, 31));
          wb_addr[s] = a;
          wb_data[s] = $urandom;
        end
        #1;
        g = m_grant();
        exp_g = (g >= 0) ? (3'b001 << g) : 3'b000;
        n_checks++; if (iss_ready !== m_ready()) $display("FAIL rnd_iss_ready c=%0d got=%b want=%b", c, iss_ready, m_ready()); else n_pass++;
        n_checks++; if (wb_ready !== exp_g) $display("FAIL rnd_wb_ready c=%0d got=%b want=%b", c, wb_ready, exp_g); else n_pass++;
        n_checks++; if (rd_w_en !== m_wen) $display("FAIL rnd_rd_w_en c=%0d got=%b want=%b", c, rd_w_en, m_wen); else n_pass++;
        n_checks++; if (rd_addr !== m_addr) $display("FAIL rnd_rd_addr c=%0d got=%0d want=%0d", c, rd_addr, m_addr); else n_pass++;
        n_checks++; if (rd_data !== m_data) $display("FAIL rnd_rd_data c=%0d got=%h want=%h", c, rd_data, m_data); else n_pass++;
        n_checks++; if (sb_err !== m_err) $display("FAIL rnd_sb_err c=%0d got=%b want=%b", c, sb_err, m_err); else n_pass++;
        cycle();
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_x0();
    test_sb_err();
    test_async_reset();
    test_fwd_latency();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
